// File: rtl/miniled_pkg.sv
// Shared types and constants for the mini-LED zone scanner.
// MINILED_GAMMA_EN adds the WAIT2 state used by the gamma stage.
package miniled_pkg;

  localparam int ZONE_ADDR_W  = 10;
  localparam int ZONE_DATA_W  = 8;
  localparam int ZONE_NUM_DEF = 1024;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
`ifdef MINILED_GAMMA_EN
    WAIT2,
`endif
    SHIFT,
    LATCH,
    DONE
  } state_e;

  // Top 8 bits of the full 16-bit square.
  function automatic logic [ZONE_DATA_W-1:0] gamma8(
    input logic [ZONE_DATA_W-1:0] d
  );
    logic [2*ZONE_DATA_W-1:0] p;
    p = {8'h00, d} * {8'h00, d};
    return p[2*ZONE_DATA_W-1:ZONE_DATA_W];
  endfunction

endpackage

// File: rtl/miniled_gamma.sv
// Registered 8x8 squarer returning the top byte.
// Built only when MINILED_GAMMA_EN is defined.
module miniled_gamma
  import miniled_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ZONE_DATA_W-1:0] d_i,
  output logic [ZONE_DATA_W-1:0] q_o
);

  logic [ZONE_DATA_W-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= gamma8(d_i);
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/miniled_zone_scan.sv
// Zone-buffer scanner: shifts zone bytes MSB first to an LED driver chain.
// MINILED_GAMMA_EN inserts a registered gamma stage before the shifter.
module miniled_zone_scan
  import miniled_pkg::*;
#(
  parameter int ZONE_NUM = ZONE_NUM_DEF,
  parameter int CLK_DIV  = 4,
  parameter int LAT_CYC  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  output logic [ZONE_ADDR_W-1:0] rd_addr,
  input  logic [ZONE_DATA_W-1:0] rd_data,
  output logic                   sclk,
  output logic                   sdo,
  output logic                   lat,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int LAT_W = $clog2(LAT_CYC + 1);

  localparam logic [ZONE_ADDR_W-1:0] ZONE_LAST =
    ZONE_ADDR_W'(ZONE_NUM - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LAT_CYC - 1);

  state_e                 state_q;
  logic [ZONE_ADDR_W-1:0] zone_q;
  logic [2:0]             bit_q;
  logic [DIV_W-1:0]       div_q;
  logic [LAT_W-1:0]       lat_cnt_q;
  logic [ZONE_DATA_W-1:0] shreg_q;
  logic                   sclk_q;
  logic                   sdo_q;
  logic                   lat_q;
  logic                   busy_q;
  logic                   done_q;
  logic [ZONE_DATA_W-1:0] load_d;

`ifdef MINILED_GAMMA_EN
  logic [ZONE_DATA_W-1:0] gamma_q;

  miniled_gamma u_gamma (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rd_data),
    .q_o   (gamma_q)
  );

  assign load_d = gamma_q;
`else
  assign load_d = rd_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      zone_q    <= '0;
      bit_q     <= '0;
      div_q     <= '0;
      lat_cnt_q <= '0;
      shreg_q   <= '0;
      sclk_q    <= 1'b0;
      sdo_q     <= 1'b0;
      lat_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (frame_start) begin
            state_q <= FETCH;
            zone_q  <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        FETCH: begin
          state_q <= WAIT;
        end
`ifdef MINILED_GAMMA_EN
        WAIT: begin
          state_q <= WAIT2;
        end
        WAIT2: begin
`else
        WAIT: begin
`endif
          state_q <= SHIFT;
          shreg_q <= load_d;
          sdo_q   <= load_d[ZONE_DATA_W-1];
          div_q   <= '0;
          sclk_q  <= 1'b0;
          bit_q   <= '0;
        end
        SHIFT: begin
          if (div_q != DIV_LAST) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              // Falling edge: next bit goes out while sclk is low.
              sclk_q <= 1'b0;
              if (bit_q != 3'd7) begin
                bit_q   <= bit_q + 1'b1;
                shreg_q <= {shreg_q[ZONE_DATA_W-2:0], 1'b0};
                sdo_q   <= shreg_q[ZONE_DATA_W-2];
              end else begin
                sdo_q <= 1'b0;
                if (zone_q == ZONE_LAST) begin
                  state_q   <= LATCH;
                  lat_q     <= 1'b1;
                  lat_cnt_q <= '0;
                end else begin
                  zone_q  <= zone_q + 1'b1;
                  state_q <= FETCH;
                end
              end
            end
          end
        end
        LATCH: begin
          if (lat_cnt_q == LAT_LAST) begin
            lat_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            lat_cnt_q <= lat_cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rd_addr    = zone_q;
  assign sclk       = sclk_q;
  assign sdo        = sdo_q;
  assign lat        = lat_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: doc/miniled_zone_scan.md
MINILED_ZONE_SCAN -- requirements
Module: miniled_zone_scan

Interface
REQ-001 The block SHALL have parameter ZONE_NUM, default 1024, meaning the number of zones scanned per frame (1..1024).
REQ-002 The block SHALL have parameter CLK_DIV, default 4, meaning the SCLK half-period in clk cycles (>=1).
REQ-003 The block SHALL have parameter LAT_CYC, default 8, meaning the LAT high width in clk cycles (>=1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock, the same clk that drives the zone-buffer writer.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port frame_start, input, 1 bit: single-cycle pulse from the writer when all zone bytes for a frame are in the buffer.
REQ-007 The block SHALL have port rd_addr, output, 10 bits: zone-buffer read address.
REQ-008 The block SHALL have port rd_data, input, 8 bits: zone brightness, valid exactly 1 clk after rd_addr.
REQ-009 The block SHALL have port sclk, output, 1 bit: serial clock to the LED driver chain.
REQ-010 The block SHALL have port sdo, output, 1 bit: serial data, MSB first.
REQ-011 The block SHALL have port lat, output, 1 bit: driver latch strobe.
REQ-012 The block SHALL have port busy, output, 1 bit: high from the accepted frame_start until frame_done.
REQ-013 The block SHALL have port frame_done, output, 1 bit: single-cycle pulse when the latch completes.

Function
REQ-014 The FSM SHALL have states IDLE, FETCH, WAIT, SHIFT, LATCH, DONE.
REQ-015 In IDLE, frame_start SHALL move the FSM to FETCH, clear the zone counter and the bit counter, and set busy on the next clk.
REQ-016 In FETCH, rd_addr SHALL equal the zone counter, and the FSM SHALL move to WAIT.
REQ-017 In WAIT, the shift register SHALL load the processed rd_data, and the FSM SHALL move to SHIFT.
REQ-018 In SHIFT, sdo SHALL present the shift-register MSB, and sclk SHALL be low for CLK_DIV clk cycles and then high for CLK_DIV clk cycles per bit.
REQ-019 sdo SHALL change only while sclk is low, and the driver samples it on the sclk rising edge.
REQ-020 After 8 bits, if the zone counter is ZONE_NUM-1, the FSM SHALL move to LATCH; otherwise it SHALL increment the zone counter and return to FETCH.
REQ-021 sclk SHALL end low.
REQ-022 In LATCH, lat SHALL be high for exactly LAT_CYC clk cycles, with sclk low and sdo 0.
REQ-023 In DONE, frame_done SHALL be 1 for one clk, the FSM SHALL return to IDLE, and busy SHALL deassert in the same cycle the FSM reaches IDLE.
REQ-024 A frame_start while busy SHALL be ignored, with no queuing and no restart.
REQ-025 Per-zone time SHALL be 2 + 16*CLK_DIV clk cycles; with the gamma stage compiled in it SHALL be 3 + 16*CLK_DIV.
REQ-026 When the zone counter reaches ZONE_NUM-1 it SHALL stop and never wrap to 0 within a frame.
REQ-027 With ZONE_NUM=1024, rd_addr SHALL reach 1023 and no 11th address bit SHALL exist.
REQ-028 A frame_start arriving in the same cycle as frame_done SHALL be ignored, because busy is still high.

Reset
REQ-029 When rst_n is low, the FSM SHALL be in IDLE, all counters SHALL be 0, and rd_addr, sclk, sdo, lat, busy and frame_done SHALL all be 0, regardless of clk.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately, with no lat pulse and no frame_done.
REQ-031 After rst_n deasserts, the block SHALL wait in IDLE for a new frame_start.

Configuration
REQ-032 With macro MINILED_GAMMA_EN defined, each byte SHALL pass through the gamma stage before loading: out = (d*d) >> 8 using the full 16-bit product.
REQ-033 With MINILED_GAMMA_EN defined, the gamma stage SHALL add one registered cycle, giving an extra WAIT2 state.
REQ-034 With MINILED_GAMMA_EN undefined, rd_data SHALL load unmodified and no WAIT2 state SHALL exist.

Structure
REQ-035 The shared package miniled_pkg SHALL hold the FSM state enum, ZONE_ADDR_W=10, ZONE_DATA_W=8 and the default ZONE_NUM.
REQ-036 Sub-module miniled_gamma (registered 8x8 squarer, top 8 bits out) SHALL be instantiated only under MINILED_GAMMA_EN.
REQ-037 All other logic, including the clock divider and counters, SHALL live in miniled_zone_scan.

Verification
REQ-038 Reset, then one frame_start with ZONE_NUM=4, CLK_DIV=1 and buffer {0xA5,0x3C,0xFF,0x00} -> sdo bit stream 10100101 00111100 11111111 00000000, 32 sclk rises, then lat high 8 cycles, then one frame_done.
REQ-039 CLK_DIV=4 with a single zone -> sclk period of 8 clk, total 66 clk from FETCH to LATCH entry, and rd_addr=0 only.
REQ-040 A second frame_start pulsed mid-SHIFT and again on the frame_done cycle -> exactly one frame transmitted, and busy low after DONE.
REQ-041 rst_n pulled low during zone 2 of 4 -> all outputs 0 asynchronously, no lat, no frame_done; a new frame_start then scans zones 0..3 correctly.
REQ-042 With MINILED_GAMMA_EN and bytes 0x80, 0xFF, 0x10 -> transmitted bytes 0x40, 0xFE, 0x01, and per-zone time of 3+16*CLK_DIV.
REQ-043 With ZONE_NUM=1024 -> rd_addr goes 0..1023 monotonically, exactly 8192 sclk rises, and a single lat pulse.
